// File: rtl/tone_pkg.sv
// Shared constants for the tone generator: octave/note codes, FSM states and
// the note frequency table used to derive half periods at elaboration time.
package tone_pkg;

  localparam int OCT_NORMAL = 0;
  localparam int OCT_LOW    = 1;
  localparam int OCT_HIGH   = 2;
  localparam int NOTE_REST  = 0;

  // do..si in centi-hertz so rounding stays in integer arithmetic
  localparam longint FREQ_CHZ [1:7] = '{
    64'd26163, 64'd29366, 64'd32963, 64'd34923, 64'd39200, 64'd44000, 64'd49388
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tone_state_e;

  function automatic longint half_period(input longint clk_hz, input int note);
    if (note < 1 || note > 7) return 64'd0;
    return (clk_hz * 100 + FREQ_CHZ[note]) / (2 * FREQ_CHZ[note]);
  endfunction

endpackage

// File: rtl/tone_gen_if.sv
// Note-source bus between the mode controllers (master) and the tone
// generator (slave), plus the generator's status and speaker outputs.
interface tone_gen_if #(
  parameter int N_SRC  = 6,
  parameter int NOTE_W = 3,
  parameter int OCT_W  = 2
);
  localparam int SEL_W = $clog2(N_SRC);

  logic                      enable;
  logic [N_SRC*NOTE_W-1:0]   src_note;
  logic [N_SRC*OCT_W-1:0]    src_oct;
  logic [SEL_W-1:0]          src_sel;
  logic                      speaker;
  logic                      tone_active;
  logic                      note_ack;

  modport master (
    output enable, src_note, src_oct, src_sel,
    input  speaker, tone_active, note_ack
  );

  modport slave (
    input  enable, src_note, src_oct, src_sel,
    output speaker, tone_active, note_ack
  );
endinterface

// File: rtl/tone_period_lut.sv
// Combinational (note, octave) -> half-period lookup; rests and codes
// outside do..si yield 0.
module tone_period_lut
  import tone_pkg::*;
#(
  parameter longint CLK_HZ = 100_000_000,
  parameter int     NOTE_W = 3,
  parameter int     OCT_W  = 2,
  parameter int     CNT_W  = 32
) (
  input  logic [NOTE_W-1:0] note,
  input  logic [OCT_W-1:0]  oct,
  output logic [CNT_W-1:0]  hp
);

  localparam logic [CNT_W-1:0] HP_TAB [8] = '{
    '0,
    CNT_W'(half_period(CLK_HZ, 1)), CNT_W'(half_period(CLK_HZ, 2)),
    CNT_W'(half_period(CLK_HZ, 3)), CNT_W'(half_period(CLK_HZ, 4)),
    CNT_W'(half_period(CLK_HZ, 5)), CNT_W'(half_period(CLK_HZ, 6)),
    CNT_W'(half_period(CLK_HZ, 7))
  };

  logic [CNT_W-1:0] base;

  always_comb begin
    base = '0;
    for (int k = 1; k <= 7; k++) begin
      if (note == NOTE_W'(k)) base = HP_TAB[k];
    end
  end

  always_comb begin
    if (oct == OCT_W'(OCT_LOW))
      hp = base << 1;
    else if (oct == OCT_W'(OCT_HIGH))
      hp = base >> 1;
    else
      hp = base;
  end

endmodule

// File: rtl/tone_gen.sv
// Square-wave tone generator: source mux, registered half-period request and
// a generator that only applies a new half period on a waveform edge.
//
// state   | meaning
// ST_IDLE | silent, waiting for a non-zero half-period request
// ST_RUN  | counting half periods and toggling speaker
module tone_gen
  import tone_pkg::*;
#(
  parameter longint CLK_HZ = 100_000_000,
  parameter int     N_SRC  = 6,
  parameter int     NOTE_W = 3,
  parameter int     OCT_W  = 2,
  parameter int     CNT_W  = 32
) (
  input logic       clk,
  input logic       rst_n,
  tone_gen_if.slave bus
);

  localparam int SEL_W = $clog2(N_SRC);

  logic [NOTE_W-1:0] sel_note;
  logic [OCT_W-1:0]  sel_oct;
  logic              sel_valid;
  logic [CNT_W-1:0]  lut_hp;
  logic [CNT_W-1:0]  req_hp;
  logic [CNT_W-1:0]  active_hp;
  logic [CNT_W-1:0]  cnt;
  tone_state_e       state;

  always_comb begin
    sel_note  = '0;
    sel_oct   = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (bus.src_sel == SEL_W'(i)) begin
        sel_note  = bus.src_note[i*NOTE_W +: NOTE_W];
        sel_oct   = bus.src_oct[i*OCT_W +: OCT_W];
        sel_valid = 1'b1;
      end
    end
  end

  tone_period_lut #(
    .CLK_HZ (CLK_HZ),
    .NOTE_W (NOTE_W),
    .OCT_W  (OCT_W),
    .CNT_W  (CNT_W)
  ) u_lut (
    .note (sel_note),
    .oct  (sel_oct),
    .hp   (lut_hp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      req_hp <= '0;
    else if (bus.enable && sel_valid)
      req_hp <= lut_hp;
    else
      req_hp <= '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      active_hp       <= '0;
      cnt             <= '0;
      bus.speaker     <= 1'b0;
      bus.tone_active <= 1'b0;
      bus.note_ack    <= 1'b0;
    end else begin
      bus.note_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          bus.speaker <= 1'b0;
          if (req_hp != '0) begin
            active_hp       <= req_hp;
            cnt             <= '0;
            bus.note_ack    <= 1'b1;
            bus.tone_active <= 1'b1;
            state           <= ST_RUN;
          end
        end
        ST_RUN: begin
          // a rest silences immediately, even on the cycle a wrap would occur
          if (req_hp == '0) begin
            bus.speaker     <= 1'b0;
            cnt             <= '0;
            active_hp       <= '0;
            bus.tone_active <= 1'b0;
            state           <= ST_IDLE;
          end else if (cnt == active_hp - CNT_W'(1)) begin
            bus.speaker <= ~bus.speaker;
            cnt         <= '0;
            if (req_hp != active_hp) begin
              active_hp    <= req_hp;
              bus.note_ack <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
